// File: rtl/memristor_bank_prog_if.sv
// Command/response bus between the crossbar controller (master) and the
// memristor bank programmer (slave).
interface memristor_bank_prog_if #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned R_W   = 16,
  parameter int unsigned AMP_W = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [ChW-1:0]   cmd_ch;
  logic [AMP_W-1:0] cmd_amp;
  logic [CNT_W-1:0] cmd_npulse;
  logic [R_W-1:0]   cmd_target;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [ChW-1:0]   rsp_ch;
  logic [R_W-1:0]   rsp_r;
  logic [CNT_W-1:0] rsp_pulses;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_amp, cmd_npulse, cmd_target, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_ch, rsp_r, rsp_pulses, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_amp, cmd_npulse, cmd_target, rsp_ready,
    output cmd_ready, rsp_valid, rsp_ch, rsp_r, rsp_pulses, rsp_err
  );
endinterface

// File: rtl/memristor_bank_prog.sv
// Memristor bank programmer: quantised resistance state for N_CH channels,
// driven by read / SET / RESET / init commands. SET/RESET pulses move the
// state by an amount proportional to the remaining headroom, scaled by the
// amplitude above threshold, and clamped to [R_MIN, R_MAX].
// Optional program-and-verify early stop: define MEMRISTOR_BANK_VERIFY_EN.
module memristor_bank_prog #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned R_W     = 16,
  parameter int unsigned AMP_W   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PW_CYC  = 4,
  parameter int unsigned R_MIN   = 4096,
  parameter int unsigned R_MAX   = 61440,
  parameter int unsigned R_INIT  = 40000,
  parameter int unsigned V_TH    = 2,
  parameter int unsigned SHIFT_P = 4,
  parameter int unsigned SHIFT_N = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  memristor_bank_prog_if.slave       bus,
  output logic                       pulse_active_o,
  output logic                       busy_o
);

  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PrW = R_W + AMP_W;
  localparam int unsigned PwW = (PW_CYC > 1) ? $clog2(PW_CYC) : 1;

  localparam logic [R_W-1:0]   RMin   = R_W'(R_MIN);
  localparam logic [R_W-1:0]   RMax   = R_W'(R_MAX);
  localparam logic [R_W-1:0]   RInit  = R_W'(R_INIT);
  localparam logic [AMP_W-1:0] VTh    = AMP_W'(V_TH);
  localparam logic [PwW-1:0]   PwLast = PwW'(PW_CYC - 1);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpSet   = 2'b01;
  localparam logic [1:0] OpReset = 2'b10;
  localparam logic [1:0] OpInit  = 2'b11;

  typedef enum logic [1:0] {StIdle, StPulse, StUpdate, StResp} state_e;

  state_e           state_q, state_d;
  logic [R_W-1:0]   r_q [N_CH];
  logic [R_W-1:0]   r_d [N_CH];
  logic [1:0]       op_q, op_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic [CNT_W-1:0] npulse_q, npulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PwW-1:0]   pw_q, pw_d;
  logic             rsp_err_q, rsp_err_d;
  logic [ChW-1:0]   rsp_ch_q, rsp_ch_d;
  logic [R_W-1:0]   rsp_r_q, rsp_r_d;
  logic [CNT_W-1:0] rsp_pulses_q, rsp_pulses_d;

  function automatic logic ch_in_range(input logic [ChW-1:0] ch);
    return 32'(ch) < N_CH;
  endfunction

  // Update law for the latched channel; only consumed in StUpdate.
  logic [ChW-1:0]   cur_idx;
  logic [R_W-1:0]   cur_r;
  logic [R_W-1:0]   head;
  logic [R_W-1:0]   r_new;
  logic [AMP_W-1:0] k;
  logic [PrW-1:0]   prod;
  logic [PrW-1:0]   delta;

  always_comb begin
    cur_idx = ch_in_range(ch_q) ? ch_q : '0;
    cur_r   = r_q[cur_idx];
    k       = (amp_q > VTh) ? amp_q - VTh : '0;
    if (op_q == OpSet) begin
      head = (cur_r > RMin) ? cur_r - RMin : '0;
    end else begin
      head = (cur_r < RMax) ? RMax - cur_r : '0;
    end
    prod  = PrW'(head) * PrW'(k);
    delta = (op_q == OpSet) ? (prod >> SHIFT_P) : (prod >> SHIFT_N);
    // Any above-threshold pulse moves the state by at least one LSB.
    if (delta == '0) begin
      delta = PrW'(1);
    end
    if (k == '0) begin
      r_new = cur_r;
    end else if (delta >= PrW'(head)) begin
      r_new = (op_q == OpSet) ? RMin : RMax;
    end else if (op_q == OpSet) begin
      r_new = cur_r - R_W'(delta);
    end else begin
      r_new = cur_r + R_W'(delta);
    end
  end

  // Early-stop condition for program-and-verify.
  logic target_met;
`ifdef MEMRISTOR_BANK_VERIFY_EN
  logic [R_W-1:0] target_q;

  // Latch the verify target alongside the other command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
    end else if (state_q == StIdle && bus.cmd_valid) begin
      target_q <= bus.cmd_target;
    end
  end

  assign target_met = (op_q == OpSet) ? (r_new <= target_q) : (r_new >= target_q);
`else
  logic unused_target;
  assign unused_target = ^bus.cmd_target;
  assign target_met    = 1'b0;
`endif

  // Command decode, pulse timing and response capture.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    op_d         = op_q;
    ch_d         = ch_q;
    amp_d        = amp_q;
    npulse_d     = npulse_q;
    cnt_d        = cnt_q;
    pw_d         = pw_q;
    rsp_err_d    = rsp_err_q;
    rsp_ch_d     = rsp_ch_q;
    rsp_r_d      = rsp_r_q;
    rsp_pulses_d = rsp_pulses_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d         = bus.cmd_op;
          ch_d         = bus.cmd_ch;
          amp_d        = bus.cmd_amp;
          npulse_d     = bus.cmd_npulse;
          cnt_d        = '0;
          pw_d         = '0;
          rsp_ch_d     = bus.cmd_ch;
          rsp_pulses_d = '0;
          if (!ch_in_range(bus.cmd_ch)) begin
            rsp_err_d = 1'b1;
            rsp_r_d   = '0;
            state_d   = StResp;
          end else if ((bus.cmd_op == OpSet || bus.cmd_op == OpReset) &&
                       bus.cmd_npulse != '0) begin
            rsp_err_d = 1'b0;
            state_d   = StPulse;
          end else begin
            rsp_err_d = 1'b0;
            if (bus.cmd_op == OpInit) begin
              r_d[bus.cmd_ch] = RInit;
              rsp_r_d         = RInit;
            end else begin
              rsp_r_d = r_q[bus.cmd_ch];
            end
            state_d = StResp;
          end
        end
      end
      StPulse: begin
        if (pw_q == PwLast) begin
          pw_d    = '0;
          state_d = StUpdate;
        end else begin
          pw_d = pw_q + PwW'(1);
        end
      end
      StUpdate: begin
        r_d[cur_idx] = r_new;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_d == npulse_q || target_met) begin
          rsp_r_d      = r_new;
          rsp_pulses_d = cnt_d;
          state_d      = StResp;
        end else begin
          state_d = StPulse;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any command in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      for (int i = 0; i < N_CH; i++) begin
        r_q[i] <= RInit;
      end
      op_q         <= OpRead;
      ch_q         <= '0;
      amp_q        <= '0;
      npulse_q     <= '0;
      cnt_q        <= '0;
      pw_q         <= '0;
      rsp_err_q    <= 1'b0;
      rsp_ch_q     <= '0;
      rsp_r_q      <= '0;
      rsp_pulses_q <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      op_q         <= op_d;
      ch_q         <= ch_d;
      amp_q        <= amp_d;
      npulse_q     <= npulse_d;
      cnt_q        <= cnt_d;
      pw_q         <= pw_d;
      rsp_err_q    <= rsp_err_d;
      rsp_ch_q     <= rsp_ch_d;
      rsp_r_q      <= rsp_r_d;
      rsp_pulses_q <= rsp_pulses_d;
    end
  end

  // Outputs decoded directly from state and response registers.
  always_comb begin
    bus.cmd_ready  = (state_q == StIdle);
    bus.rsp_valid  = (state_q == StResp);
    bus.rsp_ch     = rsp_ch_q;
    bus.rsp_r      = rsp_r_q;
    bus.rsp_pulses = rsp_pulses_q;
    bus.rsp_err    = rsp_err_q;
    pulse_active_o = (state_q == StPulse);
    busy_o         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_memristor_bank_prog.sv
// Directed bench for memristor_bank_prog: a vector table of commands with
// hand-computed results, plus sequences for out-of-range, back-pressure and
// mid-pulse reset. A second instance with N_CH=6 exercises rsp_err.
module tb_memristor_bank_prog;

  localparam int PW = 4;
  localparam logic [1:0] OP_RD = 2'b00, OP_SET = 2'b01, OP_RST = 2'b10, OP_INIT = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse_active, busy;
  logic pulse_active6, busy6;

  always #5 clk = ~clk;

  memristor_bank_prog_if #(.N_CH(8), .R_W(16), .AMP_W(4), .CNT_W(8)) bus ();
  memristor_bank_prog_if #(.N_CH(6), .R_W(16), .AMP_W(4), .CNT_W(8)) bus6 ();

  memristor_bank_prog #(.N_CH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .pulse_active_o (pulse_active),
    .busy_o         (busy)
  );

  memristor_bank_prog #(.N_CH(6)) dut6 (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus6),
    .pulse_active_o (pulse_active6),
    .busy_o         (busy6)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  ch;
    logic [3:0]  amp;
    logic [7:0]  np;
    logic [15:0] tgt;
    logic [15:0] r;
    logic [7:0]  p;
    logic        err;
    int          lat;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input int ch, input int amp, input int np,
                              input int tgt, input int r, input int p);
    vec_t v;
    v.op  = op;
    v.ch  = 3'(ch);
    v.amp = 4'(amp);
    v.np  = 8'(np);
    v.tgt = 16'(tgt);
    v.r   = 16'(r);
    v.p   = 8'(p);
    v.err = 1'b0;
    v.lat = (p == 0) ? 1 : 1 + p * (PW + 1);
    return v;
  endfunction

  // Issue one command on the N_CH=8 instance and check the full response.
  task automatic run_cmd(input vec_t v, input string tag);
    int lat;
    int pact;
    @(negedge clk);
    check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = v.op;
    bus.cmd_ch     = v.ch;
    bus.cmd_amp    = v.amp;
    bus.cmd_npulse = v.np;
    bus.cmd_target = v.tgt;
    bus.rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat  = 1;
    pact = 0;
    while (!bus.rsp_valid && lat < 3000) begin
      if (pulse_active) pact++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " rsp_r"}, 32'(bus.rsp_r), 32'(v.r));
    check({tag, " rsp_pulses"}, 32'(bus.rsp_pulses), 32'(v.p));
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(v.err));
    check({tag, " rsp_ch"}, 32'(bus.rsp_ch), 32'(v.ch));
    check({tag, " pulse_active cycles"}, 32'(pact), 32'(int'(v.p) * PW));
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_ch = '0; bus.cmd_amp = '0;
    bus.cmd_npulse = '0; bus.cmd_target = '0; bus.rsp_ready = 1'b0;
    bus6.cmd_valid = 1'b0; bus6.cmd_op = '0; bus6.cmd_ch = '0; bus6.cmd_amp = '0;
    bus6.cmd_npulse = '0; bus6.cmd_target = '0; bus6.rsp_ready = 1'b0;

    // Vector table: hand-computed resistances.
    for (int i = 0; i < 8; i++) vecs.push_back(mk(OP_RD, i, 0, 0, 0, 40000, 0));
`ifdef MEMRISTOR_BANK_VERIFY_EN
    vecs.push_back(mk(OP_SET, 0, 6, 10, 30000, 24292, 2));
`else
    vecs.push_back(mk(OP_SET, 0, 6, 10, 30000, 6119, 10));
`endif
    vecs.push_back(mk(OP_SET, 3, 6, 1, 0, 31024, 1));
    vecs.push_back(mk(OP_RD, 2, 0, 0, 0, 40000, 0));
    vecs.push_back(mk(OP_RD, 3, 0, 0, 0, 31024, 0));
    vecs.push_back(mk(OP_RST, 5, 6, 1, 65535, 42680, 1));
    vecs.push_back(mk(OP_INIT, 5, 6, 5, 0, 40000, 0));
    vecs.push_back(mk(OP_RD, 5, 0, 0, 0, 40000, 0));
    vecs.push_back(mk(OP_SET, 1, 2, 3, 0, 40000, 3));
    vecs.push_back(mk(OP_SET, 2, 15, 255, 0, 4096, 255));
    vecs.push_back(mk(OP_SET, 2, 15, 1, 0, 4096, 1));
    vecs.push_back(mk(OP_RST, 4, 3, 1, 65535, 40670, 1));
    vecs.push_back(mk(OP_SET, 6, 9, 0, 0, 40000, 0));
`ifdef MEMRISTOR_BANK_VERIFY_EN
    vecs.push_back(mk(OP_SET, 7, 6, 5, 50000, 31024, 1));
    vecs.push_back(mk(OP_RD, 0, 0, 0, 0, 24292, 0));
    vecs.push_back(mk(OP_RD, 7, 0, 0, 0, 31024, 0));
`else
    vecs.push_back(mk(OP_SET, 7, 6, 5, 50000, 12617, 5));
    vecs.push_back(mk(OP_RD, 0, 0, 0, 0, 6119, 0));
    vecs.push_back(mk(OP_RD, 7, 0, 0, 0, 12617, 0));
`endif
    vecs.push_back(mk(OP_RD, 4, 0, 0, 0, 40670, 0));
    vecs.push_back(mk(OP_RD, 1, 0, 0, 0, 40000, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset pulse_active", 32'(pulse_active), 32'd0);
    check("reset rsp_r", 32'(bus.rsp_r), 32'd0);
    check("reset rsp_pulses", 32'(bus.rsp_pulses), 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);

    foreach (vecs[i]) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Out-of-range channel on the N_CH=6 instance, then hold the response.
    @(negedge clk);
    bus6.cmd_valid = 1'b1; bus6.cmd_op = OP_RD; bus6.cmd_ch = 3'd7;
    @(posedge clk);
    #1;
    bus6.cmd_valid = 1'b0;
    check("oor rsp_valid", 32'(bus6.rsp_valid), 32'd1);
    check("oor rsp_err", 32'(bus6.rsp_err), 32'd1);
    check("oor rsp_r", 32'(bus6.rsp_r), 32'd0);
    check("oor rsp_pulses", 32'(bus6.rsp_pulses), 32'd0);
    check("oor rsp_ch", 32'(bus6.rsp_ch), 32'd7);
    // A competing command while the response is stalled must be ignored.
    bus6.cmd_valid = 1'b1; bus6.cmd_op = OP_SET; bus6.cmd_ch = 3'd0;
    bus6.cmd_amp = 4'd15; bus6.cmd_npulse = 8'd1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d rsp_valid", c), 32'(bus6.rsp_valid), 32'd1);
      check($sformatf("hold%0d rsp_err", c), 32'(bus6.rsp_err), 32'd1);
      check($sformatf("hold%0d rsp_ch", c), 32'(bus6.rsp_ch), 32'd7);
      check($sformatf("hold%0d cmd_ready", c), 32'(bus6.cmd_ready), 32'd0);
    end
    bus6.cmd_valid = 1'b0;
    @(negedge clk);
    bus6.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus6.rsp_ready = 1'b0;
    check("oor released", 32'(bus6.rsp_valid), 32'd0);
    @(negedge clk);
    bus6.cmd_valid = 1'b1; bus6.cmd_op = OP_RD; bus6.cmd_ch = 3'd0;
    @(posedge clk);
    #1;
    bus6.cmd_valid = 1'b0;
    check("n6 ch0 rsp_r", 32'(bus6.rsp_r), 32'd40000);
    check("n6 ch0 rsp_err", 32'(bus6.rsp_err), 32'd0);
    @(negedge clk);
    bus6.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus6.rsp_ready = 1'b0;

    // Reset in the middle of a pulse train aborts without a response.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_SET; bus.cmd_ch = 3'd0;
    bus.cmd_amp = 4'd15; bus.cmd_npulse = 8'd3; bus.cmd_target = '0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst pulse_active before", 32'(pulse_active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst pulse_active", 32'(pulse_active), 32'd0);
    check("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid || busy) lat++;
    end
    check("midrst no response", 32'(lat), 32'd0);
    for (int i = 0; i < 8; i++) run_cmd(mk(OP_RD, i, 0, 0, 0, 40000, 0), $sformatf("post%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/memristor_bank_prog.md
Name: memristor_bank_prog

Overview:
- Digital, cycle-based successor to the team's analytical memristor device model.
- Holds quantised resistance state for N_CH memristor channels.
- Executes host program commands: SET pulses (toward R_MIN), RESET pulses (toward R_MAX), read and re-init.
- Update law: amplitude-threshold, bounded, proportional-to-headroom. Sits between the crossbar controller and the analog array front-end.

Parameters:
- N_CH, 8, number of channels.
- R_W, 16, resistance state width (unsigned, 1 LSB = 1 ohm).
- AMP_W, 4, pulse amplitude code width.
- CNT_W, 8, pulse count width.
- PW_CYC, 4, clock cycles per pulse (>=1).
- R_MIN, 4096, lower resistance bound.
- R_MAX, 61440, upper resistance bound.
- R_INIT, 40000, reset/init resistance.
- V_TH, 2, amplitude codes <= V_TH cause no state change.
- SHIFT_P, 4, SET rate right-shift.
- SHIFT_N, 5, RESET rate right-shift.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 read, 01 set, 10 reset, 11 init.
- cmd_ch  in  $clog2(N_CH)  channel index.
- cmd_amp  in  AMP_W  pulse amplitude code.
- cmd_npulse  in  CNT_W  pulse count.
- cmd_target  in  R_W  verify target (used only with optional feature).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_ch  out  $clog2(N_CH)  channel of response.
- rsp_r  out  R_W  resistance after command.
- rsp_pulses  out  CNT_W  pulses actually applied.
- rsp_err  out  1  channel index >= N_CH.
- pulse_active  out  1  high while a pulse is being driven.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - All channel states = R_INIT; FSM = IDLE.
  - rsp_valid, rsp_err, pulse_active, busy, rsp_r, rsp_pulses, rsp_ch = 0; cmd_ready = 1 after reset release.
  - Reset mid-command aborts the command with no response.
- Command capture: accepted on a clk edge with cmd_valid & cmd_ready; all cmd fields are latched on that edge.
- FSM states: IDLE, PULSE, UPDATE, RESP.
  - IDLE -> RESP on read, init, npulse=0, or out-of-range channel.
  - IDLE -> PULSE on set/reset with npulse>0.
  - PULSE: stays exactly PW_CYC cycles with pulse_active=1, then -> UPDATE.
  - UPDATE: 1 cycle. Applies the update law, increments the pulse counter, then -> PULSE if pulses remain, else -> RESP.
  - RESP: rsp_valid=1, holds all rsp_* stable until rsp_ready; -> IDLE on handshake.
- Latency: response valid at cycle 1 + npulse*(PW_CYC+1) after accept; 1 cycle for read/init/npulse=0.
- Update law, with k = cmd_amp - V_TH and products in R_W+AMP_W bits:
  - k <= 0 (amp <= V_TH): R unchanged; pulses still timed and counted.
  - SET: d = ((R - R_MIN)*k) >> SHIFT_P; if d = 0 then d = 1; R' = max(R - d, R_MIN).
  - RESET: d = ((R_MAX - R)*k) >> SHIFT_N; if d = 0 then d = 1; R' = min(R + d, R_MAX).
  - R already at its bound: unchanged; no wrap, no underflow/overflow.
- Init: channel state = R_INIT; rsp_pulses = 0.
- Read: no state change.
- Out-of-range channel: rsp_err=1, rsp_r=0, rsp_pulses=0, no state change.
- Other channels never change during a command.
- cmd_valid while busy is ignored (cmd_ready=0).

Optional Feature:
- MEMRISTOR_BANK_VERIFY_EN defined: program-and-verify.
  - After each UPDATE, terminate early -> RESP if (SET and R' <= cmd_target) or (RESET and R' >= cmd_target).
  - rsp_pulses reports pulses applied.
  - Target already met before the first pulse still applies one pulse.
- Undefined: cmd_target is ignored; all npulse pulses are always applied.

Test Plan:
- Reset, then read ch0..ch7 -> each rsp_r=40000, rsp_pulses=0, rsp_err=0, response 1 cycle after accept.
- Set ch3 amp=6 n=1 -> rsp_r=31024, rsp_pulses=1, rsp_valid 6 cycles after accept; pulse_active high 4 cycles; other channels still 40000.
- Reset ch5 amp=6 n=1 -> rsp_r=42680; then init ch5 -> 40000.
- Set ch1 amp=2 n=3 -> rsp_r=40000, rsp_pulses=3, pulse_active high 12 cycles total.
- Set ch2 amp=15 n=255 -> rsp_r=4096 exactly, no underflow. Then read ch8 with N_CH=8 via cmd_ch=3'b... override (N_CH=6, ch 7) -> rsp_err=1. Hold rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0; assert rst_n=0 mid-pulse -> all channels 40000, no response.
- With MEMRISTOR_BANK_VERIFY_EN: set ch0 amp=6 n=10 target=30000 -> rsp_r=24292, rsp_pulses=2. Without the macro, the same stimulus -> rsp_pulses=10.
